shift_unit_pipe: RTL and testbench

//  Parametrised, pipelined shift/rotate unit with a valid/ready stream interface.

---
 rtl/shift_unit_pipe_pkg.sv | 19 +
 rtl/shift_unit_pipe_if.sv | 29 ++
 rtl/shift_unit_pipe_core.sv | 67 ++++++
 rtl/shift_unit_pipe.sv | 96 +++++++++
 tb/tb_shift_unit_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_unit_pipe_pkg.sv
// Shared op codes for the pipelined shift/rotate unit.
// Used by the datapath core, the pipe top and the bench.
package shift_unit_pipe_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SLA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    // Any code with both upper bits set is illegal.
    localparam logic [2:0] OP_ILL_MASK = 3'b110;

    function automatic logic op_illegal(input logic [2:0] op);
        return (op & OP_ILL_MASK) == OP_ILL_MASK;
    endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Valid/ready stream bundle for the shift unit.
// master: issue/writeback side; slave: the shift unit.
interface shift_unit_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SAW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [SAW-1:0]   in_amt;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_amt, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_op, in_amt, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_err
    );

endinterface

// File: rtl/shift_unit_pipe_core.sv
// shift_core: combinational log barrel (op, amt, data) -> (res, ovf, err).
// Ports: op_i/amt_i/data_i in; res_o/ovf_o/err_o out.
module shift_core
    import shift_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SAW = $clog2(WIDTH)
) (
    input  logic [2:0]       op_i,
    input  logic [SAW-1:0]   amt_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o,
    output logic             err_o
);

    localparam logic [SAW:0] ONE = 1;

    logic             illegal;
    logic             left;
    logic             rot;
    logic             fill;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] top_mask;
    logic [WIDTH-1:0] top_bits;
    logic [SAW:0]     amt_p1;
    logic [WIDTH-1:0] stg [SAW+1];

    always_comb begin
        illegal = op_illegal(op_i);
        left    = (op_i == OP_SLL) || (op_i == OP_SLA) || (op_i == OP_ROL);
        rot     = (op_i == OP_ROL) || (op_i == OP_ROR);
        fill    = (op_i == OP_SRA) && data_i[WIDTH-1];
        // Left ops run through the right barrel on bit-reversed data.
        src = '0;
        for (int i = 0; i < WIDTH; i++) begin
            src[i] = left ? data_i[WIDTH-1-i] : data_i[i];
        end
    end

    assign stg[0] = src;

    for (genvar s = 0; s < SAW; s++) begin : g_bar
        localparam int SH = 1 << s;
        assign stg[s+1] = !amt_i[s] ? stg[s] :
                          rot ? {stg[s][SH-1:0], stg[s][WIDTH-1:SH]} :
                                {{SH{fill}}, stg[s][WIDTH-1:SH]};
    end

    always_comb begin
        // Top amt+1 bits must all agree for SLA to be lossless.
        amt_p1   = {1'b0, amt_i} + ONE;
        top_mask = ~({WIDTH{1'b1}} >> amt_p1);
        top_bits = data_i & top_mask;
        res_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_o[i] = left ? stg[SAW][WIDTH-1-i] : stg[SAW][i];
        end
        if (illegal) begin
            res_o = data_i;
        end
        err_o = illegal;
        ovf_o = (op_i == OP_SLA) &&
                (top_bits != '0) && (top_bits != top_mask);
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: 2-stage elastic shift/rotate pipe, latency 2.
// Ports: clk, rst (async, active high), sif (slave stream bundle).
module shift_unit_pipe
    import shift_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SAW = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rst,
    shift_unit_pipe_if.slave sif
);

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [SAW-1:0]   s1_amt_q, s1_amt_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic             s2_err_q, s2_err_d;

    logic             s1_adv, s2_adv, accept;
    logic [WIDTH-1:0] core_res;
    logic             core_ovf, core_err;

    shift_core #(.WIDTH(WIDTH)) u_core (
        .op_i   (s1_op_q),
        .amt_i  (s1_amt_q),
        .data_i (s1_data_q),
        .res_o  (core_res),
        .ovf_o  (core_ovf),
        .err_o  (core_err)
    );

    always_comb begin
        s2_adv = !s2_valid_q || sif.out_ready;
        s1_adv = !s1_valid_q || s2_adv;
        accept = sif.in_valid && s1_adv;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_amt_d   = s1_amt_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ovf_d   = s2_ovf_q;
        s2_err_d   = s2_err_q;

        if (s1_adv) begin
            s1_valid_d = sif.in_valid;
        end
        if (accept) begin
            s1_op_d   = sif.in_op;
            s1_amt_d  = sif.in_amt;
            s1_data_d = sif.in_data;
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q) begin
            s2_data_d = core_res;
            s2_ovf_d  = core_ovf;
            s2_err_d  = core_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_amt_q   <= '0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_amt_q   <= s1_amt_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign sif.in_ready  = s1_adv;
    assign sif.out_valid = s2_valid_q;
    assign sif.out_data  = s2_data_q;
    assign sif.out_ovf   = s2_ovf_q;
    assign sif.out_err   = s2_err_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: directed literals plus random traffic
// checked against an arithmetic model and an in-order scoreboard.
module tb_shift_unit_pipe;
    import shift_unit_pipe_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [7:0] d;
        logic       ovf;
        logic       err;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_unit_pipe_if #(.WIDTH(W)) sif ();

    shift_unit_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;
    res_t q[$];
    logic hold_prev = 1'b0;
    res_t prev;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [2:0] op, input int amt,
                                   input logic [7:0] d);
        res_t r;
        int   x;
        int   s;
        int   top;
        x = int'(d);
        s = (x >= 128) ? x - 256 : x;
        r.ovf = 1'b0;
        r.err = 1'b0;
        case (op)
            OP_SLL, OP_SLA: r.d = 8'(x << amt);
            OP_SRL:         r.d = 8'(x >> amt);
            OP_SRA:         r.d = 8'(s >>> amt);
            OP_ROL:         r.d = 8'((x << amt) | (x >> (W - amt)));
            OP_ROR:         r.d = 8'((x >> amt) | (x << (W - amt)));
            default: begin
                r.d   = d;
                r.err = 1'b1;
            end
        endcase
        if (op == OP_SLA) begin
            top   = x >> (W - 1 - amt);
            r.ovf = !(top == 0 || top == (1 << (amt + 1)) - 1);
        end
        return r;
    endfunction

    // Single compare process: scoreboard, hold-stability and ready checks.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold_prev = 1'b0;
        end else begin
            chk("in_ready", int'(sif.in_ready),
                int'((q.size() < 2) || sif.out_ready));
            if (hold_prev) begin
                chk("hold_valid", int'(sif.out_valid), 1);
                chk("hold_data", int'(sif.out_data), int'(prev.d));
                chk("hold_flags", int'({sif.out_ovf, sif.out_err}),
                    int'({prev.ovf, prev.err}));
            end
            if (sif.out_valid) begin
                chk("result_expected", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    chk("out_data", int'(sif.out_data), int'(q[0].d));
                    chk("out_ovf", int'(sif.out_ovf), int'(q[0].ovf));
                    chk("out_err", int'(sif.out_err), int'(q[0].err));
                    if (sif.out_ready) begin
                        void'(q.pop_front());
                        n_pops++;
                    end
                end
            end
            if (sif.in_valid && sif.in_ready) begin
                q.push_back(model(sif.in_op, int'(sif.in_amt), sif.in_data));
            end
            hold_prev = sif.out_valid && !sif.out_ready;
            prev.d    = sif.out_data;
            prev.ovf  = sif.out_ovf;
            prev.err  = sif.out_err;
        end
    end

    task automatic do_op(input string name, input logic [2:0] op,
                         input logic [2:0] amt, input logic [7:0] d,
                         input logic [7:0] ed, input logic eo,
                         input logic ee);
        int n;
        @(posedge clk); #1;
        sif.in_valid  = 1'b1;
        sif.in_op     = op;
        sif.in_amt    = amt;
        sif.in_data   = d;
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sif.out_valid && n < 10);
        chk({name, "_lat"}, n, 2);
        chk({name, "_data"}, int'(sif.out_data), int'(ed));
        chk({name, "_ovf"}, int'(sif.out_ovf), int'(eo));
        chk({name, "_err"}, int'(sif.out_err), int'(ee));
    endtask

    // Holds the op until accepted; returns at posedge+1 with valid still high.
    task automatic send(input logic [2:0] op, input logic [2:0] amt,
                        input logic [7:0] d);
        logic acc;
        int   n;
        sif.in_valid = 1'b1;
        sif.in_op    = op;
        sif.in_amt   = amt;
        sif.in_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            acc = sif.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        chk("send_accepted", int'(acc), 1);
    endtask

    task automatic drain(input string name);
        int n;
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || sif.out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, int'(q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        logic [7:0] dv;
        rst           = 1'b1;
        sif.in_valid  = 1'b0;
        sif.in_op     = 3'b000;
        sif.in_amt    = 3'd0;
        sif.in_data   = 8'h00;
        sif.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", int'(sif.out_valid), 0);
        chk("rst_out_data", int'(sif.out_data), 0);
        chk("rst_flags", int'({sif.out_ovf, sif.out_err}), 0);
        #10 rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(sif.in_ready), 1);

        do_op("sra", OP_SRA, 3'd3, 8'h90, 8'hF2, 1'b0, 1'b0);
        do_op("srl", OP_SRL, 3'd3, 8'h90, 8'h12, 1'b0, 1'b0);
        do_op("sll", OP_SLL, 3'd2, 8'h81, 8'h04, 1'b0, 1'b0);
        do_op("rol", OP_ROL, 3'd1, 8'h81, 8'h03, 1'b0, 1'b0);
        do_op("ror", OP_ROR, 3'd1, 8'h81, 8'hC0, 1'b0, 1'b0);
        for (int op = 0; op < 6; op++) begin
            do_op($sformatf("amt0_op%0d", op), 3'(op), 3'd0, 8'h81,
                  8'h81, 1'b0, 1'b0);
        end
        do_op("sla_ovf", OP_SLA, 3'd1, 8'h40, 8'h80, 1'b1, 1'b0);
        do_op("sla_ok", OP_SLA, 3'd2, 8'hF0, 8'hC0, 1'b0, 1'b0);
        do_op("illegal", 3'b110, 3'd4, 8'h5A, 8'h5A, 1'b0, 1'b1);
        drain("directed");

        // Stream of 4 with the consumer stalled at first.
        @(posedge clk); #1;
        pops0 = n_pops;
        sif.out_ready = 1'b0;
        fork
            begin
                send(OP_SRL, 3'd3, 8'h90);
                send(OP_SLL, 3'd2, 8'h81);
                send(OP_ROL, 3'd1, 8'h81);
                send(OP_ROR, 3'd1, 8'h81);
                sif.in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                chk("stall_in_ready", int'(sif.in_ready), 0);
                chk("stall_head", int'(sif.out_data), 8'h12);
                repeat (2) @(negedge clk);
                chk("stall_head_held", int'(sif.out_data), 8'h12);
                chk("stall_valid_held", int'(sif.out_valid), 1);
                @(posedge clk); #1;
                sif.out_ready = 1'b1;
            end
        join
        drain("stream");
        chk("stream_pops", n_pops - pops0, 4);

        // Asynchronous reset with two ops in flight.
        @(posedge clk); #1;
        sif.out_ready = 1'b0;
        send(OP_ROR, 3'd1, 8'h81);
        send(OP_SRA, 3'd3, 8'h90);
        sif.in_valid = 1'b0;
        chk("pre_rst_valid", int'(sif.out_valid), 1);
        chk("pre_rst_data", int'(sif.out_data), 8'hC0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(sif.out_valid), 0);
        chk("async_rst_data", int'(sif.out_data), 0);
        chk("async_rst_flags", int'({sif.out_ovf, sif.out_err}), 0);
        #13 rst = 1'b0;
        sif.out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", int'(sif.in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_result", int'(sif.out_valid), 0);
        end

        // Random traffic with random backpressure.
        pops0 = n_pops;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            sif.in_valid  = ($urandom_range(0, 3) != 0);
            sif.in_op     = 3'($urandom_range(0, 7));
            sif.in_amt    = 3'($urandom_range(0, 7));
            dv            = 8'($urandom);
            sif.in_data   = dv;
            sif.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        drain("random");
        chk("random_traffic", int'(n_pops - pops0 > 1000), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
